// File: rtl/vsmac_pkg.sv
// Shared types and sizing helpers for the vector-scalar MAC stream block.
package vsmac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Full-precision accumulator: a product plus headroom for max_acc additions.
    function automatic int acc_width(input int width, input int max_acc);
        return 2 * width + $clog2(max_acc);
    endfunction

endpackage

// File: rtl/vsmac_lane.sv
// One MAC lane: multiply, accumulate, round-half-up, saturate, optional ReLU.
module vsmac_lane
    import vsmac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 6,
    parameter int MAX_ACC   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    accum,
    input  logic                    round,
    input  logic                    relu,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] data,
    output logic                    sat
);
    localparam int ACC_W = acc_width(WIDTH, MAX_ACC);
    // One extra bit so the rounding bias can never wrap the accumulator.
    localparam int RW    = ACC_W + 1;

    localparam logic signed [RW-1:0] HALF = RW'((1 << FRAC_BITS) >> 1);
    localparam logic signed [RW-1:0] MAXV = RW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = RW'(-(1 << (WIDTH - 1)));

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [RW-1:0]      biased;
    logic signed [RW-1:0]      shifted;
    logic signed [RW-1:0]      clamped;
    logic signed [WIDTH-1:0]   res;
    logic                      clipped;

    assign prod    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign biased  = RW'(acc) + HALF;
    assign shifted = biased >>> FRAC_BITS;

    always_comb begin
        clipped = 1'b0;
        clamped = shifted;
        if (shifted > MAXV) begin
            clamped = MAXV;
            clipped = 1'b1;
        end else if (shifted < MINV) begin
            clamped = MINV;
            clipped = 1'b1;
        end
        res = WIDTH'(clamped);
        // ReLU acts after clipping so sat still reports negative saturation.
        if (relu && res[WIDTH-1]) res = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            data <= '0;
            sat  <= 1'b0;
        end else begin
            if (load)       acc <= ACC_W'(prod);
            else if (accum) acc <= acc + ACC_W'(prod);
            if (round) begin
                data <= res;
                sat  <= clipped;
            end
        end
    end

endmodule

// File: rtl/vsmac_stream.sv
// Streaming vector x scalar MAC: accumulates runs of beats across LANES lanes,
// then emits one rounded, saturated result vector with a valid/ready handshake.
module vsmac_stream
    import vsmac_pkg::*;
#(
    parameter int LANES     = 6,
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 6,
    parameter int MAX_ACC   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]               in_b,
    input  logic [$clog2(MAX_ACC+1)-1:0]   acc_len,
    input  logic                           relu_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*WIDTH-1:0]         out_data,
    output logic [LANES-1:0]               out_sat
);
    localparam int CW = $clog2(MAX_ACC + 1);

    state_t         state;
    logic [CW-1:0]  len;
    logic [CW-1:0]  len_in;
    logic [CW-1:0]  count;
    logic           relu_q;
    logic           accept;
    logic           load;
    logic           accum;

    always_comb begin
        len_in = acc_len;
        if (acc_len == '0)                 len_in = CW'(1);
        else if (acc_len > CW'(MAX_ACC))   len_in = CW'(MAX_ACC);
    end

    // Gated by reset so upstream sees not-ready for the whole reset window.
    assign in_ready = !reset && (state == IDLE || state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign load     = accept && (state == IDLE);
    assign accum    = accept && (state == ACCUM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            count     <= '0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    len    <= len_in;
                    relu_q <= relu_en;
                    count  <= CW'(1);
                    state  <= (len_in == CW'(1)) ? ROUND : ACCUM;
                end
                ACCUM: if (accept) begin
                    count <= count + CW'(1);
                    if (count + CW'(1) == len) state <= ROUND;
                end
                ROUND: begin
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vsmac_lane #(
            .WIDTH     (WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .MAX_ACC   (MAX_ACC)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .accum (accum),
            .round (state == ROUND),
            .relu  (relu_q),
            .a     (in_a[WIDTH*i +: WIDTH]),
            .b     (in_b),
            .data  (out_data[WIDTH*i +: WIDTH]),
            .sat   (out_sat[i])
        );
    end

endmodule

// File: tb/tb_vsmac_stream.sv
// Scoreboard bench for vsmac_stream: expected vectors are queued as each run's
// last beat is driven and popped when the DUT presents a result.
module tb_vsmac_stream;
    localparam int LANES = 6, WIDTH = 8, FRAC_BITS = 6, MAX_ACC = 16;
    localparam int DW = LANES * WIDTH;

    logic             clk = 0, reset = 1, in_valid = 0, out_ready = 1, relu_en = 0;
    logic             in_ready, out_valid;
    logic [DW-1:0]    in_a = '0, out_data;
    logic [WIDTH-1:0] in_b = '0;
    logic [4:0]       acc_len = '0;
    logic [LANES-1:0] out_sat;

    typedef struct { logic [DW-1:0] data; logic [LANES-1:0] sat; } exp_t;
    exp_t sb[$];
    int   msum[LANES];
    int   total = 0, bad = 0;

    vsmac_stream #(.LANES(LANES), .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .MAX_ACC(MAX_ACC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .acc_len(acc_len), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drives one beat until accepted, then scrambles the inputs; updates the model sums.
    task automatic drive_beat(input logic [DW-1:0] a, input logic [7:0] b,
                              input logic [4:0] len, input bit relu, input bit first);
        bit done = 0;
        @(negedge clk);
        in_valid = 1; in_a = a; in_b = b; acc_len = len; relu_en = relu;
        for (int c = 0; c < 50 && !done; c++) begin
            if (in_ready) begin @(posedge clk); done = 1; end
            else @(negedge clk);
        end
        #1;
        in_valid = 0;
        in_a = {$urandom, $urandom}; in_b = 8'($urandom);
        acc_len = 5'($urandom); relu_en = 1'($urandom);
        if (!done) begin
            total++; bad++;
            $display("FAIL beat_accept: in_ready=%b, want 1 within 50 cycles", in_ready);
        end else begin
            for (int i = 0; i < LANES; i++)
                msum[i] = (first ? 0 : msum[i])
                        + int'($signed(a[WIDTH*i +: WIDTH])) * int'($signed(b));
        end
    endtask

    function automatic void push_exp(input bit relu);
        exp_t e;
        int   r;
        e.data = '0; e.sat = '0;
        for (int i = 0; i < LANES; i++) begin
            r = (msum[i] + (1 << (FRAC_BITS - 1))) >>> FRAC_BITS;
            e.sat[i] = (r > 127) || (r < -128);
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
            if (relu && r < 0) r = 0;
            e.data[WIDTH*i +: WIDTH] = r[WIDTH-1:0];
        end
        sb.push_back(e);
    endfunction

    task automatic wait_out(output bit ok);
        ok = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
    endtask

    task automatic run(input logic [4:0] len, input int beats, input bit relu,
                       input logic [DW-1:0] a, input logic [7:0] b, input bit rnd);
        logic [DW-1:0] av;
        logic [7:0]    bv;
        for (int k = 0; k < beats; k++) begin
            av = rnd ? {$urandom, $urandom} : a;
            bv = rnd ? 8'($urandom) : b;
            drive_beat(av, bv, len, relu, k == 0);
        end
        push_exp(relu);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 0 || out_data !== '0 || out_sat !== '0 || in_ready !== 0) begin
            bad++;
            $display("FAIL reset_state: valid=%b data=%h sat=%b rdy=%b, want 0 0 0 0",
                     out_valid, out_data, out_sat, in_ready);
        end
        reset = 0;
        @(negedge clk);
        total++;
        if (in_ready !== 1) begin bad++; $display("FAIL reset_release: in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_basic();
        exp_t e;
        run(5'd3, 3, 0, {LANES{8'd64}}, 8'd32, 0);
        e = sb.pop_front();
        @(negedge clk);
        total++;
        if (out_valid !== 0 || in_ready !== 0) begin
            bad++; $display("FAIL basic_round_cycle: valid=%b rdy=%b want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1 || out_data !== e.data || out_sat !== e.sat || e.data !== {LANES{8'd96}}) begin
            bad++;
            $display("FAIL basic_result: valid=%b data=%h sat=%b want 1 data=%h sat=%b",
                     out_valid, out_data, out_sat, e.data, e.sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        logic [7:0] av [3] = '{8'd127, 8'h80, 8'h80};
        bit         rl [3] = '{0, 0, 1};
        exp_t e;
        bit   ok;
        for (int t = 0; t < 3; t++) begin
            run(5'd4, 4, rl[t], {LANES{av[t]}}, 8'd127, 0);
            wait_out(ok);
            e = sb.pop_front();
            total++;
            if (!ok || out_data !== e.data || out_sat !== e.sat) begin
                bad++;
                $display("FAIL saturate_%0d: valid=%b data=%h sat=%b want data=%h sat=%b",
                         t, ok, out_data, out_sat, e.data, e.sat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_len_edges();
        logic [4:0] lv [3] = '{5'd1, 5'd0, 5'd31};
        int         nb [3] = '{1, 1, 16};
        exp_t e;
        bit   ok;
        for (int t = 0; t < 3; t++) begin
            run(lv[t], nb[t], 0, {LANES{8'd1}}, 8'd32, t != 0);
            wait_out(ok);
            e = sb.pop_front();
            total++;
            if (!ok || out_data !== e.data || out_sat !== e.sat || (t == 0 && e.data !== {LANES{8'd1}})) begin
                bad++;
                $display("FAIL len_edge_%0d: valid=%b data=%h sat=%b want data=%h sat=%b",
                         t, ok, out_data, out_sat, e.data, e.sat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        exp_t e;
        bit   ok;
        out_ready = 0;
        run(5'd2, 2, 0, '0, '0, 1);
        wait_out(ok);
        e = sb.pop_front();
        total++;
        if (!ok || out_data !== e.data || out_sat !== e.sat) begin
            bad++; $display("FAIL hold_result: valid=%b data=%h want %h", ok, out_data, e.data);
        end
        in_valid = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1 || out_data !== e.data || out_sat !== e.sat || in_ready !== 0) begin
                bad++;
                $display("FAIL hold_stable_%0d: valid=%b data=%h rdy=%b want 1 %h 0",
                         c, out_valid, out_data, in_ready, e.data);
            end
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        total++;
        if (out_valid !== 0 || out_data !== e.data || out_sat !== e.sat || in_ready !== 1) begin
            bad++;
            $display("FAIL hold_release: valid=%b data=%h rdy=%b want 0 %h 1",
                     out_valid, out_data, in_ready, e.data);
        end
    endtask

    task automatic test_gaps();
        exp_t e;
        bit   ok;
        logic [DW-1:0] av;
        for (int k = 0; k < 4; k++) begin
            av = {$urandom, $urandom};
            drive_beat(av, 8'($urandom), 5'd4, 0, k == 0);
            if (k < 3) begin
                repeat (3) begin
                    @(negedge clk);
                    in_a = {$urandom, $urandom}; in_b = 8'($urandom);
                end
                total++;
                if (in_ready !== 1 || out_valid !== 0) begin
                    bad++; $display("FAIL gap_state_%0d: rdy=%b valid=%b want 1 0", k, in_ready, out_valid);
                end
            end
        end
        push_exp(0);
        wait_out(ok);
        e = sb.pop_front();
        total++;
        if (!ok || out_data !== e.data || out_sat !== e.sat) begin
            bad++; $display("FAIL gaps_result: data=%h sat=%b want %h %b", out_data, out_sat, e.data, e.sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        int   n;
        bit   rl;
        for (int t = 0; t < 6; t++) begin
            n  = $urandom_range(1, 5);
            rl = 1'($urandom);
            run(5'(n), n, rl, '0, '0, 1);
            wait_out(ok);
            e = sb.pop_front();
            total++;
            if (!ok || out_data !== e.data || out_sat !== e.sat) begin
                bad++;
                $display("FAIL random_%0d: data=%h sat=%b want %h %b", t, out_data, out_sat, e.data, e.sat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        run(5'd1, 1, 0, {LANES{8'd64}}, 8'd64, 0);
        wait_out(ok);
        e = sb.pop_front();
        @(posedge clk); #1;
        drive_beat({LANES{8'd100}}, 8'd50, 5'd3, 0, 1);
        drive_beat({LANES{8'd100}}, 8'd50, 5'd3, 0, 0);
        @(negedge clk);
        reset = 1;
        #1;
        total++;
        if (!ok || out_data !== '0 || out_sat !== '0 || out_valid !== 0 || in_ready !== 0) begin
            bad++;
            $display("FAIL reset_mid: prior=%b data=%h sat=%b valid=%b rdy=%b want 0s",
                     ok, out_data, out_sat, out_valid, in_ready);
        end
        @(negedge clk);
        reset = 0;
        run(5'd1, 1, 0, {LANES{8'd64}}, 8'd64, 0);
        wait_out(ok);
        e = sb.pop_front();
        total++;
        if (!ok || out_data !== e.data || out_sat !== e.sat || e.data !== {LANES{8'd64}}) begin
            bad++; $display("FAIL after_reset: data=%h sat=%b want %h %b", out_data, out_sat, e.data, e.sat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_len_edges();
        test_hold();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
